gpp_fetch_unit: RTL and testbench
=================================

# gpp_fetch_unit

Parametrised instruction-fetch front end for the general-purpose processor. It replaces the single-cycle PC register, increment adders and branch mux with a fetch unit that has explicit handshakes:
- a prefetch buffer absorbs one-cycle instruction-memory latency and decode stalls;
- one-word and two-word instructions are assembled before presentation to decode;
- branch/jump redirects flush all stale state.

## Interface
Parameters:
- ADDR_W, 16, PC / instruction-memory address width
- DATA_W, 16, instruction word width
- DEPTH, 4, prefetch buffer entries (power of two, ≥ 3)
- RESET_PC, 0, fetch address after reset
- LEN_BIT, 15, bit of the first word that marks a two-word instruction (1 = long)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- imem_req  output  1  fetch request this cycle
- imem_addr  output  ADDR_W  fetch address (registered)
- imem_rdata  input  DATA_W  word for the request issued the previous cycle
- redirect_valid  input  1  branch/jump taken; flush and restart
- redirect_pc  input  ADDR_W  new fetch address
- instr_valid  output  1  complete instruction presented
- instr_ready  input  1  decode accepts the presented instruction
- instr_pc  output  ADDR_W  address of word0
- instr_word0  output  DATA_W  first word
- instr_word1  output  DATA_W  second word; 0 for one-word instructions
- instr_long  output  1  instruction is two words
- buf_count  output  $clog2(DEPTH)+1  buffer occupancy (debug)

## Operation
Reset (rst low, asynchronous):
- fetch_pc = RESET_PC, buffer empty, inflight = 0.
- imem_req = 0; imem_addr = RESET_PC; instr_valid, instr_long, instr_pc, instr_word0 and instr_word1 = 0; buf_count = 0.

Fetch:
- imem_addr = fetch_pc.
- imem_req = !redirect_valid && (buf_count + inflight < DEPTH). The pop in the current cycle is deliberately not credited.
- On a request, fetch_pc increments by 1 and inflight is set to 1 for the next cycle.
- When inflight = 1, imem_rdata and its pc are pushed to the buffer tail.

Present:
- The buffer head is a long instruction if word[LEN_BIT] = 1.
- instr_valid = (buf_count ≥ 1 && !long) || (buf_count ≥ 2 && long).
- instr_word1 = the entry after the head.
- All instr_* outputs are driven combinationally from registered buffer state.

Consume:
- instr_valid && instr_ready pops 1 entry (short) or 2 entries (long).
- Push and pop in the same cycle are allowed. Occupancy is updated as count + push − pop.

Redirect (highest priority):
- In a redirect_valid cycle:
  - buffer flushed (count = 0);
  - the response arriving this cycle is discarded;
  - no request is issued;
  - any pop is ignored;
  - fetch_pc = redirect_pc.
- Fetch restarts in the following cycle.

Arithmetic:
- The PC wraps modulo 2^ADDR_W.
- A long instruction at 2^ADDR_W−1 takes word1 from address 0.

## Timing
- Request in cycle t; data is written at the end of t+1; the instruction is visible in t+2.
- Short-instruction throughput: one per cycle sustained with instr_ready held high.
- Long instruction: one per two cycles.
- After rst rises, or after a redirect in cycle t: first request at cycle 0 (reset) or t+1 (redirect); first instr_valid at cycle 2 (reset) or t+3 (redirect).
- Full buffer: imem_req stays low until occupancy drops. No word is ever dropped or duplicated.
- Drain: instr_valid stays high while the buffer holds a complete instruction, independent of instr_ready.
- Incomplete long instruction (only word0 buffered): instr_valid = 0 until word1 arrives.
- rst asserted mid-operation: everything returns to reset values immediately. Responses already in flight are ignored.

## Structure
- Package gpp_fetch_pkg holds:
  - default parameter constants;
  - typedef of the buffer entry {pc, word};
  - function is_long(word) using LEN_BIT.
- Sub-module fetch_word_fifo: circular buffer of entries with push, pop1 or pop2, synchronous flush, head/next outputs and count. Pointers wrap modulo DEPTH.
- The top level holds fetch_pc, the inflight flag, request logic and redirect priority.

## Test plan
- Reset release, RESET_PC = 0x0000, all words short, instr_ready = 1 → instr_valid first at cycle 2; instr_pc 0x0000, 0x0001, 0x0002 … on consecutive cycles.
- mem[0x0004] = 0x8123, mem[0x0005] = 0x00FF → one instruction with instr_long = 1, word0 = 0x8123, word1 = 0x00FF, pc = 0x0004; next instr_pc = 0x0006.
- instr_ready = 0 for 10 cycles → buf_count saturates at 4, imem_req = 0. Release → pcs continue in order with no gaps or repeats.
- Buffer full with a response in flight, redirect_valid with redirect_pc = 0x0100 → buf_count = 0 the next cycle; the first instr_valid, at t+3, has pc = 0x0100; no stale pc is ever presented.
- RESET_PC = 0xFFFF, mem[0xFFFF] long, mem[0x0000] = 0x1234 → instr_pc = 0xFFFF, word1 = 0x1234; next pc = 0x0001.
- redirect_valid and instr_ready both high while instr_valid → no pop is counted; the next instruction comes from redirect_pc.

Source files
------------

// File: rtl/gpp_fetch_pkg.sv
// Shared constants, buffer entry type and instruction-length decode for the
// general-purpose processor fetch front end.
package gpp_fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned LEN_BIT_DEF = 15;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  // Widest instruction word the length decode accepts; callers zero-extend.
  localparam int unsigned WORD_MAX_W = 64;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] word;
  } fetch_entry_t;

  function automatic logic is_long(input logic [WORD_MAX_W-1:0] word,
                                   input logic [5:0]            len_bit);
    return word[len_bit];
  endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Circular prefetch buffer of {pc, word} entries; pops one or two entries per
// cycle and exposes the head plus the entry behind it for two-word assembly.
module fetch_word_fifo #(
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_word,
  input  logic [1:0]        pop_cnt,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_word,
  output logic [DATA_W-1:0] next_word,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign head_pc   = pc_mem[rd_ptr];
  assign head_word = word_mem[rd_ptr];
  assign next_word = word_mem[rd_ptr + PTR_W'(1)];

  // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two makes
  // the modulo wrap free. The caller guarantees no overflow or underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        word_mem[wr_ptr] <= push_word;
      end
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      count  <= count + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

endmodule

// File: rtl/gpp_fetch_unit.sv
// Instruction fetch front end: sequential PC with redirect, one-cycle memory
// response capture, prefetch buffering and one/two-word instruction assembly.
module gpp_fetch_unit
  import gpp_fetch_pkg::*;
#(
  parameter  int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter  int unsigned       DATA_W   = DATA_W_DEF,
  parameter  int unsigned       DEPTH    = DEPTH_DEF,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter  int unsigned       LEN_BIT  = LEN_BIT_DEF,
  localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [DATA_W-1:0] instr_word0,
  output logic [DATA_W-1:0] instr_word1,
  output logic              instr_long,
  output logic [CNT_W-1:0]  buf_count
);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_word;
  logic [DATA_W-1:0] next_word;
  logic              head_long;
  logic              accept;
  logic              push;
  logic [1:0]        pop_cnt;

  assign imem_addr = fetch_pc;

  // Occupancy counts the outstanding response but not this cycle's pop, so a
  // request is only made when its response is guaranteed a free slot.
  assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = rst && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));

  assign head_long   = is_long(WORD_MAX_W'(head_word), 6'(LEN_BIT));
  assign instr_valid = head_long ? (buf_count >= CNT_W'(2)) : (buf_count != '0);
  assign accept      = instr_valid && instr_ready && !redirect_valid;
  assign pop_cnt     = !accept ? 2'd0 : (head_long ? 2'd2 : 2'd1);
  assign push        = inflight && !redirect_valid;

  assign instr_pc    = instr_valid ? head_pc : '0;
  assign instr_word0 = instr_valid ? head_word : '0;
  assign instr_long  = instr_valid && head_long;
  assign instr_word1 = instr_long ? next_word : '0;

  // A redirect drops the response due this cycle by clearing inflight and
  // suppressing the push; fetch resumes from redirect_pc on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_word_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_pc   (inflight_pc),
    .push_word (imem_rdata),
    .pop_cnt   (pop_cnt),
    .head_pc   (head_pc),
    .head_word (head_word),
    .next_word (next_word),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_gpp_fetch_unit.sv
// Bench for gpp_fetch_unit: per-cycle vector table after reset, hand-written
// stall/redirect/wrap/reset sequences, and an instruction-stream scoreboard.
module tb_gpp_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        lng;
  } exp_instr_t;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic        exp_long;
    logic [15:0] exp_w0;
    logic [15:0] exp_w1;
    logic [2:0]  exp_count;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_pc;
  logic [15:0] instr_word0;
  logic [15:0] instr_word1;
  logic        instr_long;
  logic [2:0]  buf_count;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  exp_instr_t  sb_q[$];
  logic [15:0] mem [0:65535];
  vector_t     vec [10];

  gpp_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_pc       (instr_pc),
    .instr_word0    (instr_word0),
    .instr_word1    (instr_word1),
    .instr_long     (instr_long),
    .buf_count      (buf_count)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected instruction stream from a start pc, walked through the memory
  // image independently of any DUT timing.
  task automatic fill_scoreboard(input logic [15:0] start);
    logic [15:0] p;
    exp_instr_t  e;
    sb_q.delete();
    p = start;
    for (int i = 0; i < 200; i++) begin
      e.pc  = p;
      e.w0  = mem[p];
      e.lng = e.w0[15];
      e.w1  = e.lng ? mem[p + 16'd1] : 16'h0000;
      sb_q.push_back(e);
      p = p + (e.lng ? 16'd2 : 16'd1);
    end
  endtask

  task automatic apply_stimulus(input logic ready, input logic redir,
                                input logic [15:0] rpc);
    @(negedge clk);
    instr_ready    = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) fill_scoreboard(rpc);
    #1;
  endtask

  function automatic vector_t vec_of(input logic ready, input logic req,
                                     input logic [15:0] addr, input logic valid,
                                     input logic [15:0] pc, input logic lng,
                                     input logic [15:0] w0, input logic [15:0] w1,
                                     input logic [2:0] cnt);
    vector_t v;
    v = '{ready, req, addr, valid, pc, lng, w0, w1, cnt};
    return v;
  endfunction

  task automatic check_vector(input string tag, input vector_t v);
    check_output({tag, "_req"},   32'(imem_req),    32'(v.exp_req));
    check_output({tag, "_addr"},  32'(imem_addr),   32'(v.exp_addr));
    check_output({tag, "_valid"}, 32'(instr_valid), 32'(v.exp_valid));
    check_output({tag, "_count"}, 32'(buf_count),   32'(v.exp_count));
    if (v.exp_valid) begin
      check_output({tag, "_pc"},   32'(instr_pc),    32'(v.exp_pc));
      check_output({tag, "_long"}, 32'(instr_long),  32'(v.exp_long));
      check_output({tag, "_w0"},   32'(instr_word0), 32'(v.exp_w0));
      check_output({tag, "_w1"},   32'(instr_word1), 32'(v.exp_w1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"},   32'(imem_req),    32'd0);
    check_output({tag, "_addr"},  32'(imem_addr),   32'd0);
    check_output({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_output({tag, "_long"},  32'(instr_long),  32'd0);
    check_output({tag, "_pc"},    32'(instr_pc),    32'd0);
    check_output({tag, "_w0"},    32'(instr_word0), 32'd0);
    check_output({tag, "_w1"},    32'(instr_word1), 32'd0);
    check_output({tag, "_count"}, 32'(buf_count),   32'd0);
  endtask

  // Every accepted instruction must be the next one the scoreboard expects.
  always begin
    @(negedge clk);
    #1;
    if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 &&
        redirect_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        check_output("sb_nonempty", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_instr_t e;
        e = sb_q.pop_front();
        check_output("sb_pc",   32'(instr_pc),    32'(e.pc));
        check_output("sb_w0",   32'(instr_word0), 32'(e.w0));
        check_output("sb_w1",   32'(instr_word1), 32'(e.w1));
        check_output("sb_long", 32'(instr_long),  32'(e.lng));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = {1'b0, a[14:0]};
    end
    mem[16'h0000] = 16'h1234;
    mem[16'h0004] = 16'h8123;
    mem[16'h0005] = 16'h00FF;
    mem[16'hFFFF] = 16'h9ABC;

    vec[0] = vec_of(1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
    vec[1] = vec_of(1, 1, 16'h0001, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0);
    vec[2] = vec_of(1, 1, 16'h0002, 1, 16'h0000, 0, 16'h1234, 16'h0000, 3'd1);
    vec[3] = vec_of(1, 1, 16'h0003, 1, 16'h0001, 0, 16'h0001, 16'h0000, 3'd1);
    vec[4] = vec_of(1, 1, 16'h0004, 1, 16'h0002, 0, 16'h0002, 16'h0000, 3'd1);
    vec[5] = vec_of(1, 1, 16'h0005, 1, 16'h0003, 0, 16'h0003, 16'h0000, 3'd1);
    vec[6] = vec_of(1, 1, 16'h0006, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd1);
    vec[7] = vec_of(1, 1, 16'h0007, 1, 16'h0004, 1, 16'h8123, 16'h00FF, 3'd2);
    vec[8] = vec_of(1, 1, 16'h0008, 1, 16'h0006, 0, 16'h0006, 16'h0000, 3'd1);
    vec[9] = vec_of(1, 1, 16'h0009, 1, 16'h0007, 0, 16'h0007, 16'h0000, 3'd1);

    rst            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fill_scoreboard(16'h0000);

    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");

    // Reset release: cycle 0 starts here, then one vector per cycle.
    @(negedge clk);
    rst         = 1'b1;
    instr_ready = vec[0].ready;
    #1;
    check_vector("start_c0", vec[0]);
    for (int i = 1; i < 10; i++) begin
      apply_stimulus(vec[i].ready, 1'b0, 16'h0000);
      check_vector($sformatf("start_c%0d", i), vec[i]);
    end

    // Decode stall: buffer fills to DEPTH, requests stop, head stays valid.
    repeat (9) apply_stimulus(1'b0, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_vector("stall_full", vec_of(0, 0, 16'h000C, 1, 16'h0008, 0, 16'h0008, 16'h0000, 3'd4));

    repeat (11) apply_stimulus(1'b1, 1'b0, 16'h0000);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("resume", vec_of(1, 1, 16'h0016, 1, 16'h0013, 0, 16'h0013, 16'h0000, 3'd2));

    // One stalled cycle leaves three entries plus a response in flight.
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    check_vector("pre_redir", vec_of(0, 1, 16'h0017, 1, 16'h0014, 0, 16'h0014, 16'h0000, 3'd2));
    apply_stimulus(1'b1, 1'b1, 16'h0100);
    check_vector("redir_t", vec_of(1, 0, 16'h0018, 1, 16'h0014, 0, 16'h0014, 16'h0000, 3'd3));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("redir_t1", vec_of(1, 1, 16'h0100, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("redir_t2", vec_of(1, 1, 16'h0101, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("redir_t3", vec_of(1, 1, 16'h0102, 1, 16'h0100, 0, 16'h0100, 16'h0000, 3'd1));
    repeat (6) apply_stimulus(1'b1, 1'b0, 16'h0000);

    // Long instruction straddling the top of the address space.
    apply_stimulus(1'b1, 1'b1, 16'hFFFF);
    check_output("wrap_t_req", 32'(imem_req), 32'd0);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("wrap_t1", vec_of(1, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("wrap_t2", vec_of(1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("wrap_half", vec_of(1, 1, 16'h0001, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd1));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("wrap_long", vec_of(1, 1, 16'h0002, 1, 16'hFFFF, 1, 16'h9ABC, 16'h1234, 3'd2));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("wrap_next", vec_of(1, 1, 16'h0003, 1, 16'h0001, 0, 16'h0001, 16'h0000, 3'd1));
    repeat (6) apply_stimulus(1'b1, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of streaming.
    @(negedge clk);
    rst = 1'b0;
    fill_scoreboard(16'h0000);
    #1;
    check_reset_values("midrst");
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vector("rerun_c0", vec_of(1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0));
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_vector("rerun_c2", vec_of(1, 1, 16'h0002, 1, 16'h0000, 0, 16'h1234, 16'h0000, 3'd1));
    repeat (8) apply_stimulus(1'b1, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
